// File: rtl/pwm_capture_if.sv
// pwm_capture_if: control, PWM input pair and measurement results of one pwm_capture.
interface pwm_capture_if #(
  parameter int CountWidth = 16
);
  logic                  i_enable;
  logic                  i_clear_fault;
  logic [1:0]            i_s;
  logic [CountWidth-1:0] o_period;
  logic [CountWidth-1:0] o_high_time;
  logic [CountWidth-1:0] o_dead_fall;
  logic [CountWidth-1:0] o_dead_rise;
  logic                  o_valid;
  logic                  o_shoot_through;
  logic                  o_timeout;
  logic                  o_stuck_high;
  modport master (
    output i_enable, i_clear_fault, i_s,
    input  o_period, o_high_time, o_dead_fall, o_dead_rise,
    input  o_valid, o_shoot_through, o_timeout, o_stuck_high
  );
  modport slave (
    input  i_enable, i_clear_fault, i_s,
    output o_period, o_high_time, o_dead_fall, o_dead_rise,
    output o_valid, o_shoot_through, o_timeout, o_stuck_high
  );
endinterface

// File: rtl/pwm_capture.sv
// pwm_capture: measures period, high time and dead times of a complementary PWM pair, flags shoot-through and stuck outputs.
module pwm_capture #(
  parameter int CountWidth    = 16,
  parameter int SyncStages    = 2,
  parameter int TimeoutCycles = 65535
) (
  input logic          i_mclk,
  input logic          i_rst,
  pwm_capture_if.slave bus
);
  localparam logic [CountWidth-1:0] TO_LIM = CountWidth'(TimeoutCycles);
  localparam logic [CountWidth-1:0] ONE    = CountWidth'(1);
  typedef enum logic [1:0] {IDLE, FIRST, RUN} state_t;
  state_t                          r_state;
  logic [SyncStages-1:0][1:0]      r_sync;
  logic [1:0]                      r_prev;
  logic [CountWidth-1:0]           r_period_cnt, r_high_cnt, r_dead_cnt;
  logic [CountWidth-1:0]           r_period, r_high, r_dead_fall, r_dead_rise;
  logic                            r_valid, r_shoot, r_timeout, r_stuck;
  logic [1:0]                      w_ss;
  logic                            w_rise0, w_rise1;
  logic [CountWidth-1:0]           w_period_inc, w_high_inc, w_dead_inc;
  assign w_ss         = r_sync[SyncStages-1];
  assign w_rise0      = w_ss[0] & ~r_prev[0];
  assign w_rise1      = w_ss[1] & ~r_prev[1];
  assign w_period_inc = (&r_period_cnt) ? r_period_cnt : r_period_cnt + ONE;
  assign w_high_inc   = (&r_high_cnt) ? r_high_cnt : r_high_cnt + ONE;
  assign w_dead_inc   = (&r_dead_cnt) ? r_dead_cnt : r_dead_cnt + ONE;
  always_ff @(posedge i_mclk or posedge i_rst) begin
    if (i_rst) begin
      r_state      <= IDLE;
      r_sync       <= '0;
      r_prev       <= '0;
      r_period_cnt <= '0;
      r_high_cnt   <= '0;
      r_dead_cnt   <= '0;
      r_period     <= '0;
      r_high       <= '0;
      r_dead_fall  <= '0;
      r_dead_rise  <= '0;
      r_valid      <= 1'b0;
      r_shoot      <= 1'b0;
      r_timeout    <= 1'b0;
      r_stuck      <= 1'b0;
    end else begin
      r_sync  <= {r_sync[SyncStages-2:0], bus.i_s};
      r_prev  <= w_ss;
      r_shoot <= (&w_ss) | (r_shoot & ~bus.i_clear_fault);
      r_valid <= 1'b0;
      if (!bus.i_enable) begin
        r_state      <= IDLE;
        r_period_cnt <= '0;
        r_high_cnt   <= '0;
        r_dead_cnt   <= '0;
        r_timeout    <= 1'b0;
      end else if (r_state == IDLE) begin
        if (w_rise0) begin
          r_state      <= FIRST;
          r_period_cnt <= ONE;
          r_high_cnt   <= ONE;
        end
      end else if (!w_rise0 && r_period_cnt == TO_LIM) begin
        r_state      <= IDLE;
        r_period_cnt <= '0;
        r_high_cnt   <= '0;
        r_dead_cnt   <= '0;
        r_timeout    <= 1'b1;
        r_stuck      <= w_ss[0];
      end else begin
        r_period_cnt <= w_rise0 ? ONE : w_period_inc;
        r_high_cnt   <= w_rise0 ? ONE : (w_ss[0] ? w_high_inc : r_high_cnt);
        r_dead_cnt   <= (w_ss == 2'b00) ? w_dead_inc : '0;
        if (w_rise1) r_dead_fall <= r_dead_cnt;
        // the IDLE-exit rise opened the first period, so this rise already closes a complete one
        if (w_rise0) begin
          r_state     <= RUN;
          r_period    <= r_period_cnt;
          r_high      <= r_high_cnt;
          r_dead_rise <= r_dead_cnt;
          r_valid     <= 1'b1;
          r_timeout   <= 1'b0;
        end
      end
    end
  end
  assign bus.o_period        = r_period;
  assign bus.o_high_time     = r_high;
  assign bus.o_dead_fall     = r_dead_fall;
  assign bus.o_dead_rise     = r_dead_rise;
  assign bus.o_valid         = r_valid;
  assign bus.o_shoot_through = r_shoot;
  assign bus.o_timeout       = r_timeout;
  assign bus.o_stuck_high    = r_stuck;
endmodule

// File: tb/tb_pwm_capture.sv
// tb_pwm_capture: directed checks of pwm_capture; unit a uses a 200-cycle timeout, unit b an 8-bit counter width.
module tb_pwm_capture;
  logic clk = 1'b0;
  logic rst_a, rst_b;
  int   n_pass = 0, n_chk = 0, n_fail = 0;
  int   va = 0, vb = 0, dbl = 0, v0;
  logic pva = 1'b0;
  always #5 clk = ~clk;
  pwm_capture_if #(.CountWidth(16)) a ();
  pwm_capture_if #(.CountWidth(8))  b ();
  pwm_capture #(.CountWidth(16), .SyncStages(2), .TimeoutCycles(200)) u_a (
    .i_mclk(clk), .i_rst(rst_a), .bus(a.slave));
  pwm_capture #(.CountWidth(8), .SyncStages(2), .TimeoutCycles(255)) u_b (
    .i_mclk(clk), .i_rst(rst_b), .bus(b.slave));
  always @(posedge clk) begin
    #1;
    if (a.o_valid) begin
      va++;
      if (pva) dbl++;
    end
    pva = a.o_valid;
    if (b.o_valid) vb++;
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    assert (got === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask
  task automatic drive(input logic [1:0] s, input int n);
    a.i_s = s;
    repeat (n) @(negedge clk);
  endtask
  task automatic period(input int hi, input int dl, input int lo, input int dr);
    drive(2'b01, hi);
    drive(2'b00, dl);
    drive(2'b10, lo);
    drive(2'b00, dr);
  endtask
  // raw S[0] rise, then the Valid window and results; consumes 4 high cycles
  task automatic rise_check(input string tag, input int p, input int h, input int df,
                            input int dr, input logic v);
    a.i_s = 2'b01;
    repeat (2) @(negedge clk);
    chk({tag, "_pre"}, a.o_valid, 0);
    @(negedge clk);
    chk({tag, "_valid"}, a.o_valid, v);
    chk({tag, "_period"}, a.o_period, p);
    chk({tag, "_high"}, a.o_high_time, h);
    chk({tag, "_deadfall"}, a.o_dead_fall, df);
    chk({tag, "_deadrise"}, a.o_dead_rise, dr);
    @(negedge clk);
    chk({tag, "_post"}, a.o_valid, 0);
  endtask
  initial begin
    rst_a = 1'b1;
    rst_b = 1'b1;
    a.i_enable = 1'b0; a.i_clear_fault = 1'b0; a.i_s = 2'b00;
    b.i_enable = 1'b0; b.i_clear_fault = 1'b0; b.i_s = 2'b00;
    repeat (3) @(negedge clk);
    chk("rst_period", a.o_period, 0);
    chk("rst_high", a.o_high_time, 0);
    chk("rst_deadfall", a.o_dead_fall, 0);
    chk("rst_deadrise", a.o_dead_rise, 0);
    chk("rst_valid", a.o_valid, 0);
    chk("rst_shoot", a.o_shoot_through, 0);
    chk("rst_timeout", a.o_timeout, 0);
    chk("rst_stuck", a.o_stuck_high, 0);
    rst_a = 1'b0;
    rst_b = 1'b0;
    a.i_enable = 1'b1;
    drive(2'b00, 5);
    period(40, 5, 50, 5);
    chk("first_rise_no_valid", va, 0);
    rise_check("lat", 100, 40, 5, 5, 1'b1);
    drive(2'b01, 36); drive(2'b00, 5); drive(2'b10, 50); drive(2'b00, 5);
    v0 = va;
    repeat (3) period(40, 5, 50, 5);
    chk("steady_valid_count", va - v0, 3);
    period(30, 3, 20, 7);
    chk("asym_deadfall_early", a.o_dead_fall, 3);
    chk("asym_deadrise_held", a.o_dead_rise, 5);
    rise_check("asym", 60, 30, 3, 7, 1'b1);
    drive(2'b01, 6);
    drive(2'b10, 10);
    rise_check("zero_dead", 20, 10, 0, 0, 1'b1);
    drive(2'b11, 1);
    drive(2'b01, 3);
    chk("shoot_set", a.o_shoot_through, 1);
    drive(2'b01, 5);
    chk("shoot_sticky", a.o_shoot_through, 1);
    a.i_clear_fault = 1'b1;
    @(negedge clk);
    a.i_clear_fault = 1'b0;
    @(negedge clk);
    chk("shoot_cleared", a.o_shoot_through, 0);
    drive(2'b11, 1);
    drive(2'b01, 1);
    a.i_clear_fault = 1'b1;
    @(negedge clk);
    a.i_clear_fault = 1'b0;
    chk("shoot_set_wins", a.o_shoot_through, 1);
    @(negedge clk);
    chk("shoot_set_wins_hold", a.o_shoot_through, 1);
    a.i_clear_fault = 1'b1;
    @(negedge clk);
    a.i_clear_fault = 1'b0;
    drive(2'b00, 5);
    a.i_s = 2'b01;
    repeat (202) @(negedge clk);
    chk("stuck_timeout_pre", a.o_timeout, 0);
    @(negedge clk);
    chk("stuck_timeout", a.o_timeout, 1);
    chk("stuck_high", a.o_stuck_high, 1);
    v0 = va;
    drive(2'b00, 5); drive(2'b10, 50); drive(2'b00, 5);
    drive(2'b01, 10);
    chk("resume_first_timeout", a.o_timeout, 1);
    drive(2'b01, 30); drive(2'b00, 5); drive(2'b10, 50); drive(2'b00, 5);
    chk("resume_no_valid", va - v0, 0);
    a.i_s = 2'b01;
    repeat (2) @(negedge clk);
    chk("resume_timeout_held", a.o_timeout, 1);
    @(negedge clk);
    chk("resume_valid", a.o_valid, 1);
    chk("resume_timeout_clr", a.o_timeout, 0);
    chk("resume_period", a.o_period, 100);
    chk("resume_high", a.o_high_time, 40);
    drive(2'b01, 17);
    a.i_enable = 1'b0;
    v0 = va;
    drive(2'b01, 20); drive(2'b00, 5); drive(2'b10, 50); drive(2'b00, 5);
    repeat (2) period(40, 5, 50, 5);
    chk("dis_no_valid", va - v0, 0);
    chk("dis_period", a.o_period, 100);
    chk("dis_high", a.o_high_time, 40);
    chk("dis_deadfall", a.o_dead_fall, 5);
    chk("dis_deadrise", a.o_dead_rise, 5);
    chk("dis_timeout", a.o_timeout, 0);
    a.i_enable = 1'b1;
    rise_check("en_first", 100, 40, 5, 5, 1'b0);
    drive(2'b01, 16); drive(2'b00, 4); drive(2'b10, 30); drive(2'b00, 6);
    rise_check("en_second", 60, 20, 4, 6, 1'b1);
    drive(2'b01, 10);
    v0 = va;
    rst_a = 1'b1;
    a.i_s = 2'b00;
    #1;
    chk("mid_rst_period", a.o_period, 0);
    chk("mid_rst_high", a.o_high_time, 0);
    chk("mid_rst_deadfall", a.o_dead_fall, 0);
    chk("mid_rst_deadrise", a.o_dead_rise, 0);
    @(negedge clk);
    rst_a = 1'b0;
    drive(2'b00, 5);
    period(20, 4, 30, 6);
    chk("rst_restart_no_valid", va - v0, 0);
    rise_check("rst_second", 60, 20, 4, 6, 1'b1);
    chk("valid_single_cycle", dbl, 0);
    b.i_enable = 1'b1;
    repeat (5) @(negedge clk);
    b.i_s = 2'b01;
    repeat (257) @(negedge clk);
    chk("sat_timeout_pre", b.o_timeout, 0);
    @(negedge clk);
    chk("sat_timeout", b.o_timeout, 1);
    chk("sat_stuck", b.o_stuck_high, 1);
    chk("sat_high_not_latched", b.o_high_time, 0);
    chk("sat_period_not_latched", b.o_period, 0);
    repeat (42) @(negedge clk);
    chk("sat_timeout_held", b.o_timeout, 1);
    chk("sat_no_valid", vb, 0);
    b.i_enable = 1'b0;
    @(negedge clk);
    chk("sat_dis_timeout_clr", b.o_timeout, 0);
    b.i_s = 2'b11;
    @(negedge clk);
    b.i_s = 2'b00;
    repeat (3) @(negedge clk);
    chk("shoot_while_disabled", b.o_shoot_through, 1);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
